// File: rtl/phys_reg_free_list.sv
// Rename-stage physical register free list: circular FIFO with a speculative head,
// a commit head and a one-cycle flush rollback. Optional stats via FREELIST_STATS_EN.
module phys_reg_free_list #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_AREGS = 32,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS,
  localparam int PTR_W     = $clog2(FL_DEPTH),
  localparam int CNT_W     = $clog2(FL_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              commit_valid,
  input  logic [PREG_W-1:0] commit_old_preg,
  input  logic              flush,
  output logic [CNT_W-1:0]  free_count,
`ifdef FREELIST_STATS_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
`endif
  output logic              init_done
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   chead_q, chead_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   spec_count_q, spec_count_d;

  logic [PREG_W-1:0]  fl_mem_q [FL_DEPTH];
  logic               mem_we;
  logic [PTR_W-1:0]   mem_waddr;
  logic [PREG_W-1:0]  mem_wdata;

  logic               run;
  logic               alloc_fire;
  logic               commit_fire;

  assign run         = (state_q == S_RUN);
  assign alloc_ready = run & (spec_count_q != '0) & ~flush;
  assign alloc_preg  = fl_mem_q[head_q];
  assign alloc_fire  = alloc_req & alloc_ready;
  assign commit_fire = run & commit_valid;
  assign free_count  = spec_count_q;
  assign init_done   = run;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    head_d       = head_q;
    chead_d      = chead_q;
    tail_d       = tail_q;
    spec_count_d = spec_count_q;
    mem_we       = 1'b0;
    mem_waddr    = tail_q;
    mem_wdata    = commit_old_preg;

    unique case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = PREG_W'(NUM_AREGS) + PREG_W'(init_cnt_q);
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == PTR_W'(FL_DEPTH - 1)) begin
          state_d      = S_RUN;
          spec_count_d = CNT_W'(FL_DEPTH);
          head_d       = '0;
          chead_d      = '0;
          tail_d       = '0;
        end
      end
      S_RUN: begin
        if (commit_fire) begin
          mem_we  = 1'b1;
          tail_d  = tail_q + 1'b1;
          chead_d = chead_q + 1'b1;
        end
        head_d       = head_q + PTR_W'(alloc_fire);
        spec_count_d = spec_count_q + CNT_W'(commit_fire)
                     - CNT_W'(alloc_fire);
        // Rollback uses the post-commit head so a retiring instr stays retired
        if (flush) begin
          head_d       = chead_d;
          spec_count_d = CNT_W'(FL_DEPTH);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      head_q       <= '0;
      chead_q      <= '0;
      tail_q       <= '0;
      spec_count_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      head_q       <= head_d;
      chead_q      <= chead_d;
      tail_q       <= tail_d;
      spec_count_q <= spec_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) fl_mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef FREELIST_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flushes_q, flushes_d;

  always_comb begin
    stall_d   = stall_q;
    flushes_d = flushes_q;
    if (run & alloc_req & ~alloc_ready & (stall_q != '1))
      stall_d = stall_q + 32'd1;
    if (run & flush & (flushes_q != '1))
      flushes_d = flushes_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      flushes_q <= '0;
    end else begin
      stall_q   <= stall_d;
      flushes_q <= flushes_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flushes_q;
`endif

  a_commit_on_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    commit_fire |-> (spec_count_q != CNT_W'(FL_DEPTH)));

  // Outstanding renames must equal the pointer gap, else commit overtook head
  a_commit_head_order: assert property (
    @(posedge clk) disable iff (!rst_n)
    run |-> (PTR_W'(head_q - chead_q) ==
             PTR_W'(CNT_W'(FL_DEPTH) - spec_count_q)));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list with a queue-based reference model
// checked every cycle on the falling edge.
module tb_phys_reg_free_list;

  logic       clk;
  logic       rst_n;
  logic       alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_preg;
  logic       commit_valid;
  logic [5:0] commit_old_preg;
  logic       flush;
  logic [5:0] free_count;
  logic       init_done;
`ifdef FREELIST_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  phys_reg_free_list dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_preg      (alloc_preg),
    .commit_valid    (commit_valid),
    .commit_old_preg (commit_old_preg),
    .flush           (flush),
    .free_count      (free_count),
`ifdef FREELIST_STATS_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .init_done       (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: free_q is the speculative free order, alloc_q the
  // renamed-but-not-retired pregs in allocation order.
  int          free_q[$];
  int          alloc_q[$];
  bit          m_run;
  int          m_icnt;
  int          m_stall;
  int          m_flush;
  bit          m_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_run   = 1'b0;
      m_icnt  = 0;
      m_stall = 0;
      m_flush = 0;
      free_q.delete();
      alloc_q.delete();
    end
    m_ready = m_run && (free_q.size() != 0) && !flush;
    chk("init_done", 32'(init_done), 32'(m_run));
    chk("alloc_ready", 32'(alloc_ready), 32'(m_ready));
    chk("free_count", 32'(free_count), m_run ? free_q.size() : 0);
    if (m_ready) chk("alloc_preg", 32'(alloc_preg), free_q[0]);
`ifdef FREELIST_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`endif
    if (rst_n) begin
      if (!m_run) begin
        m_icnt++;
        if (m_icnt == 32) begin
          m_run = 1'b1;
          for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
        end
      end else begin
        if (alloc_req && !m_ready) m_stall++;
        if (flush) m_flush++;
        if (alloc_req && m_ready) alloc_q.push_back(free_q.pop_front());
        if (commit_valid) begin
          if (alloc_q.size() > 0) void'(alloc_q.pop_front());
          free_q.push_back(int'(commit_old_preg));
        end
        if (flush) begin
          free_q = {alloc_q, free_q};
          alloc_q.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n           = 1'b0;
    alloc_req       = 1'b0;
    commit_valid    = 1'b0;
    commit_old_preg = '0;
    flush           = 1'b0;
    repeat (3) step();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_ready", 32'(alloc_ready), 0);
    chk("rst_free", 32'(free_count), 0);

    rst_n = 1'b1;
    wait_init(n);
    chk("init_len", n, 32);
    chk("init_free", 32'(free_count), 32);
    chk("init_preg", 32'(alloc_preg), 32);

    // Four allocs, commit 7, then flush
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("grant_seq", 32'(alloc_preg), 32 + i);
      step();
      if (i == 2) chk("free_after3", 32'(free_count), 29);
    end
    alloc_req       = 1'b0;
    commit_valid    = 1'b1;
    commit_old_preg = 6'd7;
    step();
    commit_valid = 1'b0;
    flush        = 1'b1;
    #1;
    chk("ready_in_flush", 32'(alloc_ready), 0);
    step();
    flush = 1'b0;
    chk("flush_free", 32'(free_count), 32);
    chk("flush_preg", 32'(alloc_preg), 33);

    // Drain the list, hold a blocked request, then return preg 5
    alloc_req = 1'b1;
    repeat (32) step();
    repeat (3) step();
    chk("empty_ready", 32'(alloc_ready), 0);
    chk("empty_free", 32'(free_count), 0);
    commit_valid    = 1'b1;
    commit_old_preg = 6'd5;
    step();
    commit_valid = 1'b0;
    chk("refill_ready", 32'(alloc_ready), 1);
    chk("refill_preg", 32'(alloc_preg), 5);
    step();
    alloc_req = 1'b0;
    chk("refill_free", 32'(free_count), 0);

    // free_count=1 with alloc and commit in the same cycle
    commit_valid    = 1'b1;
    commit_old_preg = 6'd11;
    step();
    chk("one_free", 32'(free_count), 1);
    chk("one_preg", 32'(alloc_preg), 11);
    alloc_req       = 1'b1;
    commit_old_preg = 6'd9;
    step();
    commit_valid = 1'b0;
    chk("both_free", 32'(free_count), 1);
    chk("both_preg", 32'(alloc_preg), 9);
    step();
    alloc_req = 1'b0;
    chk("both_drain", 32'(free_count), 0);

    // Build free_count=10 then reset mid-run
    commit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      commit_old_preg = 6'(20 + i);
      step();
    end
    commit_valid = 1'b0;
    chk("ten_free", 32'(free_count), 10);
    rst_n = 1'b0;
    #1;
    chk("async_ready", 32'(alloc_ready), 0);
    chk("async_init_done", 32'(init_done), 0);
    chk("async_free", 32'(free_count), 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    flush           = 1'b1;
    commit_valid    = 1'b1;
    commit_old_preg = 6'd3;
    alloc_req       = 1'b1;
    step();
    flush        = 1'b0;
    commit_valid = 1'b0;
    alloc_req    = 1'b0;
    wait_init(n);
    chk("reinit_len", n, 27);
    chk("reinit_free", 32'(free_count), 32);
    chk("reinit_preg", 32'(alloc_preg), 32);

    // Five blocked cycles then two flushes
    alloc_req = 1'b1;
    repeat (32) step();
    repeat (5) step();
    alloc_req = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("final_free", 32'(free_count), 32);
    chk("final_preg", 32'(alloc_preg), 32);
`ifdef FREELIST_STATS_EN
    chk("stats_stall", stall_cycles, 5);
    chk("stats_flush", flush_count, 2);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
